// File: rtl/bist_controller.sv
// bist_controller: host-side sequencer for the matrix_mult wrapper self-test port.
// It loads the seed, runs the PRNG driver, captures the returned signature and
// compares it against a golden value. It reports pass, fail or timeout.
// Optional feature macro: BIST_LOOPBACK_EN. When defined, the loopback_i input
// bypasses the DUT so that only the driver->monitor path is exercised.
//
// state | meaning
// IDLE  | waiting for a rising edge on start_i
// SEED  | one cycle: seed presented to the wrapper with ext_valid_o
// RUN   | driver enabled; waiting for ext_valid_i or timeout
// CHECK | one cycle: compare captured signature against golden
// DONE  | result held until the next start
module bist_controller #(
    parameter int WIDTH          = 8,
    parameter int ROW            = 4,
    parameter int COL            = 4,
    parameter int DRIVER_WIDTH   = WIDTH * (ROW + COL),
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic                    abort_i,
`ifdef BIST_LOOPBACK_EN
    input  logic                    loopback_i,
`endif
    input  logic [DRIVER_WIDTH-1:0] seed_i,
    input  logic [DRIVER_WIDTH-1:0] stop_code_i,
    input  logic [DRIVER_WIDTH-1:0] golden_i,
    output logic [2:0]              bypass_o,
    output logic [1:0]              mode_o,
    output logic                    driver_valid_o,
    output logic [DRIVER_WIDTH-1:0] driver_stop_code_o,
    output logic                    ext_en_o,
    output logic [ROW*WIDTH-1:0]    ext_input_o,
    output logic [COL*WIDTH-1:0]    ext_psum_o,
    output logic                    ext_valid_o,
    input  logic [DRIVER_WIDTH-1:0] ext_result_i,
    input  logic                    ext_valid_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timeout_o,
    output logic [DRIVER_WIDTH-1:0] signature_o,
    output logic [CNT_W-1:0]        cycle_count_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                  state;
    logic                    start_q;
    logic                    armed;
    logic [DRIVER_WIDTH-1:0] golden_q;
    logic                    start_rise;
    logic [2:0]              bypass_start;

    // armed blocks the first cycle after reset, so a start_i level that was
    // already high while reset was asserted does not count as a rising edge.
    assign start_rise = start_i & ~start_q & armed;

`ifdef BIST_LOOPBACK_EN
    assign bypass_start = loopback_i ? 3'b010 : 3'b000;
`else
    assign bypass_start = 3'b000;
`endif

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state              <= S_IDLE;
            start_q            <= 1'b0;
            armed              <= 1'b0;
            golden_q           <= '0;
            bypass_o           <= 3'b000;
            mode_o             <= 2'b00;
            driver_valid_o     <= 1'b0;
            driver_stop_code_o <= '0;
            ext_en_o           <= 1'b0;
            ext_input_o        <= '0;
            ext_psum_o         <= '0;
            ext_valid_o        <= 1'b0;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
            pass_o             <= 1'b0;
            timeout_o          <= 1'b0;
            signature_o        <= '0;
            cycle_count_o      <= '0;
        end else begin
            start_q <= start_i;
            armed   <= 1'b1;
            if (abort_i && (state != S_IDLE)) begin
                state              <= S_IDLE;
                bypass_o           <= 3'b000;
                mode_o             <= 2'b00;
                driver_valid_o     <= 1'b0;
                driver_stop_code_o <= '0;
                ext_en_o           <= 1'b0;
                ext_input_o        <= '0;
                ext_psum_o         <= '0;
                ext_valid_o        <= 1'b0;
                busy_o             <= 1'b0;
                done_o             <= 1'b0;
                pass_o             <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        // done_o rises one cycle after entering DONE
                        if (state == S_DONE) begin
                            done_o <= 1'b1;
                        end
                        if (start_rise) begin
                            state              <= S_SEED;
                            golden_q           <= golden_i;
                            driver_stop_code_o <= stop_code_i;
                            ext_input_o        <= seed_i[DRIVER_WIDTH-1 -: ROW*WIDTH];
                            ext_psum_o         <= seed_i[COL*WIDTH-1:0];
                            bypass_o           <= bypass_start;
                            mode_o             <= 2'b11;
                            ext_en_o           <= 1'b1;
                            ext_valid_o        <= 1'b1;
                            busy_o             <= 1'b1;
                            done_o             <= 1'b0;
                            pass_o             <= 1'b0;
                            timeout_o          <= 1'b0;
                            cycle_count_o      <= '0;
                        end
                    end
                    S_SEED: begin
                        state          <= S_RUN;
                        mode_o         <= 2'b00;
                        ext_valid_o    <= 1'b0;
                        driver_valid_o <= 1'b1;
                    end
                    S_RUN: begin
                        cycle_count_o <= cycle_count_o + CNT_ONE;
                        // a result arriving on the last allowed cycle still wins
                        if (ext_valid_i) begin
                            state          <= S_CHECK;
                            signature_o    <= ext_result_i;
                            driver_valid_o <= 1'b0;
                            ext_en_o       <= 1'b0;
                            bypass_o       <= 3'b000;
                            ext_input_o    <= '0;
                            ext_psum_o     <= '0;
                        end else if (cycle_count_o == CNT_LAST) begin
                            state          <= S_DONE;
                            timeout_o      <= 1'b1;
                            pass_o         <= 1'b0;
                            busy_o         <= 1'b0;
                            driver_valid_o <= 1'b0;
                            ext_en_o       <= 1'b0;
                            bypass_o       <= 3'b000;
                            ext_input_o    <= '0;
                            ext_psum_o     <= '0;
                        end
                    end
                    S_CHECK: begin
                        state  <= S_DONE;
                        pass_o <= (signature_o == golden_q);
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: randomized scoreboard bench for bist_controller
// (DRIVER_WIDTH=64, TIMEOUT_CYCLES=16).
module tb_bist_controller;

    localparam int T  = 16;
    localparam int DW = 64;

    logic          clk;
    logic          rstn;
    logic          start_i;
    logic          abort_i;
    logic [DW-1:0] seed_i;
    logic [DW-1:0] stop_code_i;
    logic [DW-1:0] golden_i;
    logic [2:0]    bypass_o;
    logic [1:0]    mode_o;
    logic          driver_valid_o;
    logic [DW-1:0] driver_stop_code_o;
    logic          ext_en_o;
    logic [31:0]   ext_input_o;
    logic [31:0]   ext_psum_o;
    logic          ext_valid_o;
    logic [DW-1:0] ext_result_i;
    logic          ext_valid_i;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic          timeout_o;
    logic [DW-1:0] signature_o;
    logic [4:0]    cycle_count_o;

    bist_controller #(
        .WIDTH(8), .ROW(4), .COL(4), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .start_i            (start_i),
        .abort_i            (abort_i),
`ifdef BIST_LOOPBACK_EN
        .loopback_i         (1'b0),
`endif
        .seed_i             (seed_i),
        .stop_code_i        (stop_code_i),
        .golden_i           (golden_i),
        .bypass_o           (bypass_o),
        .mode_o             (mode_o),
        .driver_valid_o     (driver_valid_o),
        .driver_stop_code_o (driver_stop_code_o),
        .ext_en_o           (ext_en_o),
        .ext_input_o        (ext_input_o),
        .ext_psum_o         (ext_psum_o),
        .ext_valid_o        (ext_valid_o),
        .ext_result_i       (ext_result_i),
        .ext_valid_i        (ext_valid_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .pass_o             (pass_o),
        .timeout_o          (timeout_o),
        .signature_o        (signature_o),
        .cycle_count_o      (cycle_count_o)
    );

    typedef struct {
        logic          pass;
        logic          tmo;
        logic [DW-1:0] sig;
        int            count;
        int            done_cyc;   // -1: latency not checked
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic          done_seen = 1'b0;
    logic [DW-1:0] model_sig = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each rising done_o pops one expected result from the scoreboard.
    always @(negedge clk) begin
        if (!rstn) begin
            done_seen = 1'b0;
        end else begin
            if (done_o && !done_seen) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("pass", {63'd0, pass_o}, {63'd0, mon_e.pass});
                    check("timeout", {63'd0, timeout_o}, {63'd0, mon_e.tmo});
                    check("signature", signature_o, mon_e.sig);
                    check("cycle_count", {59'd0, cycle_count_o}, DW'(mon_e.count));
                    if (mon_e.done_cyc >= 0)
                        check("done_latency", DW'(cyc), DW'(mon_e.done_cyc));
                end
            end
            done_seen = done_o;
        end
    end

    // Reference: a result in RUN cycle v (1..T) ends the run after v cycles and
    // passes iff it equals golden; otherwise the run times out after T cycles
    // and the previously captured signature is kept.
    task automatic run_test(input logic [DW-1:0] seed, input logic [DW-1:0] stop,
                            input logic [DW-1:0] golden, input logic [DW-1:0] res,
                            input int v);
        exp_t e;
        int   run1;
        if (v >= 1 && v <= T) begin
            e.pass = (res == golden); e.tmo = 1'b0; e.sig = res; e.count = v;
            model_sig = res;
        end else begin
            e.pass = 1'b0; e.tmo = 1'b1; e.sig = model_sig; e.count = T;
        end
        @(negedge clk);
        start_i = 1'b0; seed_i = seed; stop_code_i = stop; golden_i = golden; ext_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        check("seed_mode", {62'd0, mode_o}, 64'd3);
        check("seed_ext_valid", {63'd0, ext_valid_o}, 64'd1);
        check("seed_ext_en", {63'd0, ext_en_o}, 64'd1);
        check("seed_bypass", {61'd0, bypass_o}, 64'd0);
        check("seed_ext_input", {32'd0, ext_input_o}, {32'd0, seed[63:32]});
        check("seed_ext_psum", {32'd0, ext_psum_o}, {32'd0, seed[31:0]});
        check("seed_busy", {63'd0, busy_o}, 64'd1);
        check("seed_done_clear", {63'd0, done_o}, 64'd0);
        // inputs changed after start must not matter; valid in SEED is ignored
        seed_i = {$urandom, $urandom}; golden_i = ~golden;
        stop_code_i = {$urandom, $urandom};
        ext_valid_i = 1'b1; ext_result_i = {$urandom, $urandom};
        @(negedge clk);
        check("run_mode", {62'd0, mode_o}, 64'd0);
        check("run_driver_valid", {63'd0, driver_valid_o}, 64'd1);
        check("run_ext_valid_o", {63'd0, ext_valid_o}, 64'd0);
        check("run_stop_code", driver_stop_code_o, stop);
        run1 = cyc;
        e.done_cyc = (v >= 1 && v <= T) ? run1 + v + 2 : -1;
        sb.push_back(e);
        for (int k = 1; k <= T; k++) begin
            ext_valid_i  = (k == v);
            ext_result_i = (k == v) ? res : {$urandom, $urandom};
            if (k == v) break;
            if (k < T) @(negedge clk);
        end
        @(negedge clk);
        ext_valid_i = 1'b1; ext_result_i = {$urandom, $urandom};
        for (int w = 0; w < 8 && !done_o; w++) @(negedge clk);
        check("done_reached", {63'd0, done_o}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("done_held", {63'd0, done_o}, 64'd1);
        check("signature_held", signature_o, e.sig);
        ext_valid_i = 1'b0;
    endtask

    task automatic abort_test();
        @(negedge clk);
        start_i = 1'b0; seed_i = 64'h0123_4567_89AB_CDEF; golden_i = 64'h55;
        ext_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);          // SEED
        @(negedge clk);          // RUN cycle 1
        @(negedge clk);          // RUN cycle 2
        @(negedge clk);          // RUN cycle 3
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_driver_valid", {63'd0, driver_valid_o}, 64'd0);
        check("abort_done", {63'd0, done_o}, 64'd0);
        check("abort_pass", {63'd0, pass_o}, 64'd0);
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_ext_en", {63'd0, ext_en_o}, 64'd0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("abort_no_restart_busy", {63'd0, busy_o}, 64'd0);
        check("abort_no_restart_mode", {62'd0, mode_o}, 64'd0);
        start_i = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] g;
        logic [DW-1:0] r;
        int            v;
        rstn = 1'b0; start_i = 1'b1; abort_i = 1'b0;
        seed_i = '0; stop_code_i = '0; golden_i = '0;
        ext_result_i = '0; ext_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mode", {62'd0, mode_o}, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_ext_valid", {63'd0, ext_valid_o}, 64'd0);
        check("rst_signature", signature_o, 64'd0);
        check("rst_count", {59'd0, cycle_count_o}, 64'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_no_start_busy", {63'd0, busy_o}, 64'd0);
        check("post_rst_no_start_mode", {62'd0, mode_o}, 64'd0);
        start_i = 1'b0;

        run_test(64'hDEAD_BEEF_0000_0001, 64'hA5, 64'h1234, 64'h1234, 10);
        run_test(64'hDEAD_BEEF_0000_0001, 64'hA5, 64'h1234, 64'h1235, 10);
        run_test(64'h1111_2222_3333_4444, 64'h5A, 64'h77, 64'h77, 0);
        run_test(64'h1111_2222_3333_4444, 64'h5A, 64'h77, 64'h77, 16);
        run_test(64'h9999_8888_7777_6666, 64'h3C, 64'h42, 64'h42, 17);
        run_test(64'hFFFF_0000_FFFF_0000, 64'hC3, 64'h99, 64'h99, 1);
        abort_test();
        run_test(64'h0BAD_F00D_CAFE_0001, 64'h1, 64'hBEEF, 64'hBEEF, 3);

        for (int n = 0; n < 15; n++) begin
            g = {$urandom, $urandom};
            r = ($urandom_range(0, 1) == 1) ? g : (g ^ (64'd1 << $urandom_range(0, 63)));
            v = $urandom_range(0, 20);
            run_test({$urandom, $urandom}, {$urandom, $urandom}, g, r, v);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", DW'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
